// File: rtl/cpu_to_noc_flitizer_mc_if.sv
// cpu_to_noc_flitizer_mc_if
// Bundles the CPU-side request channels and the NoC injection port of the
// multi-channel flitizer. The master side is the CPU adapter / router pair
// driving requests and flit backpressure; the slave side is the flitizer.
interface cpu_to_noc_flitizer_mc_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int NODE_ID_W  = 8,
    parameter int BODY_FLITS = 4
);
    localparam int FLIT_W = DATA_W + 2;

    logic [NUM_CH-1:0]                   cpu_valid;
    logic [NUM_CH-1:0]                   cpu_ready;
    logic [NUM_CH*NODE_ID_W-1:0]         cpu_dst;
    logic [NUM_CH*BODY_FLITS*DATA_W-1:0] cpu_data;
    logic                                noc_flit_valid;
    logic                                noc_flit_ready;
    logic [FLIT_W-1:0]                   noc_flit;

    modport master (
        output cpu_valid,
        output cpu_dst,
        output cpu_data,
        output noc_flit_ready,
        input  cpu_ready,
        input  noc_flit_valid,
        input  noc_flit
    );

    modport slave (
        input  cpu_valid,
        input  cpu_dst,
        input  cpu_data,
        input  noc_flit_ready,
        output cpu_ready,
        output noc_flit_valid,
        output noc_flit
    );
endinterface

// File: rtl/cpu_to_noc_flitizer_mc.sv
// cpu_to_noc_flitizer_mc
// Accepts whole packets from NUM_CH CPU request channels, picks one per
// packet slot round-robin, and serialises it as HEAD/BODY.../TAIL flits on a
// single valid/ready NoC injection port.
// Optional feature macro: FLITIZER_CHECKSUM_EN -- appends an XOR checksum
// flit as the TAIL; otherwise the last payload word is the TAIL.
module cpu_to_noc_flitizer_mc #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int NODE_ID_W  = 8,
    parameter int PKT_ID_W   = 8,
    parameter int BODY_FLITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NODE_ID_W-1:0]       this_node_id,
    cpu_to_noc_flitizer_mc_if.slave    bus,
    output logic                       busy
);
    localparam int FLIT_W = DATA_W + 2;
    localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BEAT_W = $clog2(BODY_FLITS + 2);
`ifdef FLITIZER_CHECKSUM_EN
    localparam int LAST_BEAT = BODY_FLITS;
`else
    localparam int LAST_BEAT = BODY_FLITS - 1;
`endif

    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_BODY = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    if (DATA_W < PKT_ID_W + 2 * NODE_ID_W) begin : g_width_check
        $error("cpu_to_noc_flitizer_mc: DATA_W too narrow for {pkt_id, src, dst} head fields");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    // control state
    state_t                r_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PKT_ID_W-1:0]   r_pkt_id;
    logic [BEAT_W-1:0]     r_beat;

    // captured packet (data path, not reset)
    logic [PKT_ID_W-1:0]                  r_pkt_id_lat;
    logic [NODE_ID_W-1:0]                 r_node;
    logic [NODE_ID_W-1:0]                 r_dst;
    logic [BODY_FLITS-1:0][DATA_W-1:0]    r_words;

    state_t                               w_state_nxt;
    logic                                 w_grant_vld;
    logic [PTR_W-1:0]                     w_grant;
    logic [PTR_W-1:0]                     w_rr_nxt;
    int                                   w_dist;
    int                                   w_best;
    logic [NUM_CH-1:0]                    w_cpu_ready;
    logic                                 w_accept;
    logic [NODE_ID_W-1:0]                 w_sel_dst;
    logic [BODY_FLITS-1:0][DATA_W-1:0]    w_sel_words;
    logic [DATA_W-1:0]                    w_head;
    logic [DATA_W-1:0]                    w_word;
    logic                                 w_last;
    logic                                 w_flit_vld;
    logic [FLIT_W-1:0]                    w_flit;

    // Round-robin grant: valid channel closest to r_rr_ptr going upward (mod NUM_CH)
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_dist      = 0;
        w_best      = NUM_CH;
        for (int c = 0; c < NUM_CH; c++) begin
            w_dist = (c + NUM_CH - int'(r_rr_ptr)) % NUM_CH;
            if (bus.cpu_valid[c] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant     = PTR_W'(c);
                w_grant_vld = 1'b1;
            end
        end
    end

    // One-hot accept towards the granted channel, IDLE only; also selects its packet
    always_comb begin
        w_cpu_ready = '0;
        w_sel_dst   = '0;
        w_sel_words = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_grant == PTR_W'(c)) begin
                w_cpu_ready[c] = rst_n && (r_state == S_IDLE) && w_grant_vld;
                w_sel_dst      = bus.cpu_dst[c*NODE_ID_W +: NODE_ID_W];
                w_sel_words    = bus.cpu_data[c*BODY_FLITS*DATA_W +: BODY_FLITS*DATA_W];
            end
        end
    end

    assign w_accept = rst_n && (r_state == S_IDLE) && w_grant_vld;
    assign w_rr_nxt = (w_grant == PTR_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
    assign w_head   = DATA_W'({r_pkt_id_lat, r_node, r_dst});
    assign w_last   = (r_beat == BEAT_W'(LAST_BEAT));

    // Payload word for the current beat; beyond the data words it is the checksum
    always_comb begin
`ifdef FLITIZER_CHECKSUM_EN
        w_word = '0;
        for (int w = 0; w < BODY_FLITS; w++) begin
            w_word = w_word ^ r_words[w];
        end
`else
        w_word = '0;
`endif
        for (int w = 0; w < BODY_FLITS; w++) begin
            if (r_beat == BEAT_W'(w)) begin
                w_word = r_words[w];
            end
        end
    end

    // FSM next state and flit output; flit is forced to zero when not valid
    always_comb begin
        w_state_nxt = r_state;
        w_flit_vld  = 1'b0;
        w_flit      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_HEAD;
                end
            end
            S_HEAD: begin
                w_flit_vld = 1'b1;
                w_flit     = {TYPE_HEAD, w_head};
                if (bus.noc_flit_ready) begin
                    w_state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                w_flit_vld = 1'b1;
                w_flit     = {(w_last ? TYPE_TAIL : TYPE_BODY), w_word};
                if (bus.noc_flit_ready && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers: state, arbitration pointer, sequence id, beat counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_pkt_id <= '0;
            r_beat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_rr_nxt;
                r_pkt_id <= r_pkt_id + 1'b1;
            end
            if ((r_state == S_HEAD) && bus.noc_flit_ready) begin
                r_beat <= '0;
            end else if ((r_state == S_BODY) && bus.noc_flit_ready && !w_last) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Packet capture on accept; held for the whole packet so stalls keep flits stable
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pkt_id_lat <= r_pkt_id;
            r_node       <= this_node_id;
            r_dst        <= w_sel_dst;
            r_words      <= w_sel_words;
        end
    end

    assign bus.cpu_ready      = w_cpu_ready;
    assign bus.noc_flit_valid = w_flit_vld;
    assign bus.noc_flit       = w_flit;
    assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_cpu_to_noc_flitizer_mc.sv
// tb_cpu_to_noc_flitizer_mc
// Directed + randomized bench for cpu_to_noc_flitizer_mc. Pending packets sit
// in a queue per channel tag; a packet-level model predicts grants, pkt ids
// and the flit sequence. Honors FLITIZER_CHECKSUM_EN like the design.
module tb_cpu_to_noc_flitizer_mc;
    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 32;
    localparam int NODE_ID_W  = 8;
    localparam int PKT_ID_W   = 8;
    localparam int BODY_FLITS = 4;
    localparam int FLIT_W     = DATA_W + 2;
    localparam int PAY_W      = BODY_FLITS * DATA_W;
`ifdef FLITIZER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NODE_ID_W-1:0] this_node_id;
    logic                 busy;

    cpu_to_noc_flitizer_mc_if #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NODE_ID_W(NODE_ID_W), .BODY_FLITS(BODY_FLITS)
    ) bus ();

    cpu_to_noc_flitizer_mc #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NODE_ID_W(NODE_ID_W),
        .PKT_ID_W(PKT_ID_W), .BODY_FLITS(BODY_FLITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .this_node_id (this_node_id),
        .bus          (bus.slave),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   ch;
        logic [NODE_ID_W-1:0] dst;
        logic [PAY_W-1:0]     data;
    } pkt_t;

    pkt_t              pend[$];
    logic [FLIT_W-1:0] exp_q[$];
    int                m_rr;
    int                m_pid;
    int                flit_idx;
    int                n_assert = 0;
    int                n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PAY_W-1:0] rand_payload();
        logic [PAY_W-1:0] v;
        v = '0;
        for (int i = 0; i < BODY_FLITS; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    function automatic int front_idx(input int c);
        for (int i = 0; i < pend.size(); i++) if (pend[i].ch == c) return i;
        return -1;
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < NUM_CH; k++) if (front_idx((m_rr + k) % NUM_CH) >= 0) return (m_rr + k) % NUM_CH;
        return -1;
    endfunction

    task automatic push_pkt(input int ch, input logic [NODE_ID_W-1:0] dst, input logic [PAY_W-1:0] data);
        pkt_t p;
        p.ch = ch; p.dst = dst; p.data = data;
        pend.push_back(p);
    endtask

    // Expected flits of one accepted packet, built from the packet format rules
    task automatic model_accept(input pkt_t p);
        logic [DATA_W-1:0] hp, x, wd;
        hp = (DATA_W'(m_pid) << (2*NODE_ID_W)) | (DATA_W'(this_node_id) << NODE_ID_W) | DATA_W'(p.dst);
        exp_q.push_back({2'b00, hp});
        x = '0;
        for (int w = 0; w < BODY_FLITS; w++) begin
            wd = p.data[w*DATA_W +: DATA_W];
            x  = x ^ wd;
            exp_q.push_back({((w == BODY_FLITS-1) && !CHK) ? 2'b10 : 2'b01, wd});
        end
        if (CHK) exp_q.push_back({2'b10, x});
        m_pid = (m_pid + 1) % (1 << PKT_ID_W);
        m_rr  = (p.ch + 1) % NUM_CH;
    endtask

    task automatic drive_inputs();
        int k;
        for (int c = 0; c < NUM_CH; c++) begin
            k = front_idx(c);
            if (k >= 0) begin
                bus.cpu_valid[c] = 1'b1;
                bus.cpu_dst[c*NODE_ID_W +: NODE_ID_W] = pend[k].dst;
                bus.cpu_data[c*PAY_W +: PAY_W]        = pend[k].data;
            end else begin
                bus.cpu_valid[c] = 1'b0;
                bus.cpu_dst[c*NODE_ID_W +: NODE_ID_W] = NODE_ID_W'($urandom);
                bus.cpu_data[c*PAY_W +: PAY_W]        = rand_payload();
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rr = 0; m_pid = 0; flit_idx = 0;
    endtask

    // Entered and left at posedge+1
    task automatic do_reset();
        rst_n = 1'b0;
        bus.cpu_valid = '0;
        bus.noc_flit_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_cpu_ready", 64'(bus.cpu_ready), 64'(0));
        chk("rst_flit_valid", 64'(bus.noc_flit_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_flit", 64'(bus.noc_flit), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // rmode: 0 ready always, 1 random ready, 2 three-cycle stall on 2nd body flit
    task automatic run(input int budget, input int stop_idx, input int rmode);
        int  cyc, g, stall_left;
        bit  done, stall_done, stall_prev, acc_prev, model_idle;
        logic [FLIT_W-1:0] prev_flit, e;
        cyc = 0; done = 0; stall_left = 0; stall_done = 0; stall_prev = 0; acc_prev = 0;
        prev_flit = '0;
        drive_inputs();
        while (cyc < budget) begin
            @(negedge clk);
            model_idle = (exp_q.size() == 0);
            chk("busy", 64'(busy), 64'(!model_idle));
            chk("flit_valid", 64'(bus.noc_flit_valid), 64'(!model_idle));
            if (acc_prev) chk("head_latency", 64'(bus.noc_flit_valid), 64'(1));
            if (stall_prev) chk("stall_hold", 64'(bus.noc_flit), 64'(prev_flit));
            acc_prev = 0;
            if (model_idle) begin
                chk("idle_flit_zero", 64'(bus.noc_flit), 64'(0));
                g = exp_grant();
                chk("cpu_ready_grant", 64'(bus.cpu_ready), (g < 0) ? 64'(0) : (64'(1) << g));
                if (g >= 0) begin
                    model_accept(pend[front_idx(g)]);
                    pend.delete(front_idx(g));
                    acc_prev = 1;
                end
            end else begin
                chk("cpu_ready_busy", 64'(bus.cpu_ready), 64'(0));
                if (bus.noc_flit_valid && bus.noc_flit_ready) begin
                    e = exp_q.pop_front();
                    chk("flit", 64'(bus.noc_flit), 64'(e));
                    flit_idx = (e[FLIT_W-1 -: 2] == 2'b10) ? 0 : flit_idx + 1;
                end
            end
            stall_prev = bus.noc_flit_valid && !bus.noc_flit_ready;
            prev_flit  = bus.noc_flit;
            @(posedge clk); #1;
            cyc++;
            drive_inputs();
            case (rmode)
                0: bus.noc_flit_ready = 1'b1;
                1: bus.noc_flit_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stall_done && flit_idx == 2 && exp_q.size() > 0) begin
                        if (stall_left < 3) begin
                            bus.noc_flit_ready = 1'b0;
                            stall_left++;
                        end else begin
                            bus.noc_flit_ready = 1'b1;
                            stall_done = 1;
                        end
                    end else begin
                        bus.noc_flit_ready = 1'b1;
                    end
                end
            endcase
            if (stop_idx >= 0 && flit_idx == stop_idx) begin done = 1; break; end
            if (stop_idx < 0 && pend.size() == 0 && exp_q.size() == 0) begin done = 1; break; end
        end
        chk("run_complete", 64'(done), 64'(1));
        if (rmode == 2) chk("stall_applied", 64'(stall_left), 64'(3));
    endtask

    initial begin
        this_node_id = 8'h01;
        bus.cpu_dst  = '0;
        bus.cpu_data = '0;
        model_reset();

        // Reset state
        do_reset();

        // Single packet on ch0, first after reset carries pkt_id 0
        push_pkt(0, 8'h05, {32'h44, 32'h33, 32'h22, 32'h11});
        run(200, -1, 0);

        // Backpressure on the 2nd body flit
        push_pkt(1, 8'h3c, rand_payload());
        run(200, -1, 2);

        // Round-robin with both channels requesting, from reset
        do_reset();
        this_node_id = NODE_ID_W'($urandom);
        for (int i = 0; i < 2; i++) begin
            push_pkt(0, NODE_ID_W'($urandom), rand_payload());
            push_pkt(1, NODE_ID_W'($urandom), rand_payload());
        end
        run(400, -1, 0);

        // Random traffic past the pkt_id wrap, random backpressure
        do_reset();
        this_node_id = NODE_ID_W'($urandom);
        for (int i = 0; i < 260; i++) push_pkt(int'($urandom_range(0, NUM_CH-1)), NODE_ID_W'($urandom), rand_payload());
        run(20000, -1, 1);

        // Mid-packet reset during body beat 1
        push_pkt(1, 8'h77, rand_payload());
        run(200, 2, 0);
        rst_n = 1'b0;
        bus.noc_flit_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_valid", 64'(bus.noc_flit_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_flit", 64'(bus.noc_flit), 64'(0));
        @(posedge clk); #1;
        push_pkt(1, 8'h42, rand_payload());
        run(200, -1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
